// File: rtl/ysyx_22050612_key_search.sv
// ----------------------------------------------------------------------------
// ysyx_22050612_key_search
//
// Reverse lookup table: holds NR_KEY programmable {key, data} pairs and, given
// a data value, scans the entries one per cycle to return the key of the first
// valid entry whose data matches. If nothing matches it returns DEFAULT_KEY.
// Used wherever a value must be mapped back to its selector code.
//
// Ports:
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   wr_en/wr_idx/      write one table entry (sets valid); out-of-range
//   wr_key/wr_data     indices are ignored
//   clr                invalidate every entry (a same-edge write still lands)
//   req_valid/ready    search request handshake, req_data = value to find
//   resp_valid/ready   response handshake
//   resp_hit           1 when a matching entry was found
//   resp_key           matched key, DEFAULT_KEY on miss
//   resp_idx           matched entry index, 0 on miss
//   busy               engine is not idle
// ----------------------------------------------------------------------------
module ysyx_22050612_key_search #(
    parameter int                 NR_KEY      = 4,
    parameter int                 KEY_LEN     = 4,
    parameter int                 DATA_LEN    = 32,
    parameter logic [KEY_LEN-1:0] DEFAULT_KEY = '0,
    parameter int                 IDX_W       = (NR_KEY > 2) ? $clog2(NR_KEY) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_en,
    input  logic [IDX_W-1:0]    wr_idx,
    input  logic [KEY_LEN-1:0]  wr_key,
    input  logic [DATA_LEN-1:0] wr_data,
    input  logic                clr,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [DATA_LEN-1:0] req_data,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic                resp_hit,
    output logic [KEY_LEN-1:0]  resp_key,
    output logic [IDX_W-1:0]    resp_idx,
    output logic                busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        RESP   = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Table storage
    // ------------------------------------------------------------------
    logic                tbl_valid [NR_KEY];
    logic [KEY_LEN-1:0]  tbl_key   [NR_KEY];
    logic [DATA_LEN-1:0] tbl_data  [NR_KEY];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the table is small and must read as empty and zeroed
            // after reset, so every word is reset, not just the valid bits.
            for (int i = 0; i < NR_KEY; i++) begin
                tbl_valid[i] <= 1'b0;
                tbl_key[i]   <= '0;
                tbl_data[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NR_KEY; i++) begin
                // A write wins over clr for its own entry: clear-then-write.
                // Indices with no matching entry simply never compare equal.
                if (wr_en && (wr_idx == IDX_W'(i))) begin
                    tbl_valid[i] <= 1'b1;
                    tbl_key[i]   <= wr_key;
                    tbl_data[i]  <= wr_data;
                end else if (clr) begin
                    tbl_valid[i] <= 1'b0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Search engine
    // ------------------------------------------------------------------
    state_t              state;
    logic [DATA_LEN-1:0] q;
    logic [IDX_W-1:0]    ptr;

    // The compare sees the live table, so writes to entries not yet scanned
    // are picked up while earlier entries are already decided.
    logic hit_now;
    logic last_entry;
    assign hit_now    = tbl_valid[ptr] && (tbl_data[ptr] == q);
    assign last_entry = (ptr == IDX_W'(NR_KEY - 1));

    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of block order.
            state      <= IDLE;
            q          <= '0;
            ptr        <= '0;
            resp_valid <= 1'b0;
            resp_hit   <= 1'b0;
            resp_key   <= '0;
            resp_idx   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // req_ready is high throughout IDLE.
                    if (req_valid) begin
                        q     <= req_data;
                        ptr   <= '0;
                        state <= SEARCH;
                    end
                end
                SEARCH: begin
                    if (hit_now) begin
                        resp_hit   <= 1'b1;
                        resp_key   <= tbl_key[ptr];
                        resp_idx   <= ptr;
                        resp_valid <= 1'b1;
                        state      <= RESP;
                    end else if (last_entry) begin
                        resp_hit   <= 1'b0;
                        resp_key   <= DEFAULT_KEY;
                        resp_idx   <= '0;
                        resp_valid <= 1'b1;
                        state      <= RESP;
                    end else begin
                        ptr <= ptr + 1'b1;
                    end
                end
                RESP: begin
                    // resp_* stay untouched until the consumer takes them.
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state      <= IDLE;
                    resp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_22050612_key_search.sv
// ----------------------------------------------------------------------------
// tb_ysyx_22050612_key_search
//
// Scoreboard bench for the reverse key lookup. The driver computes the expected
// response from a plain array model of the table (first valid entry whose data
// equals the request wins; latency = index+1 on hit, NR_KEY on miss) and pushes
// it into a queue; an independent monitor pops and compares whenever the DUT
// presents a response, also checking latency and stability under back-pressure.
// ----------------------------------------------------------------------------
module tb_ysyx_22050612_key_search;

    localparam int         NR_KEY   = 4;
    localparam int         KEY_LEN  = 4;
    localparam int         DATA_LEN = 32;
    localparam int         IDX_W    = 2;
    localparam logic [3:0] DEF_KEY  = 4'hF;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                wr_en;
    logic [IDX_W-1:0]    wr_idx;
    logic [KEY_LEN-1:0]  wr_key;
    logic [DATA_LEN-1:0] wr_data;
    logic                clr;
    logic                req_valid;
    logic                req_ready;
    logic [DATA_LEN-1:0] req_data;
    logic                resp_valid;
    logic                resp_ready;
    logic                resp_hit;
    logic [KEY_LEN-1:0]  resp_key;
    logic [IDX_W-1:0]    resp_idx;
    logic                busy;

    ysyx_22050612_key_search #(
        .NR_KEY     (NR_KEY),
        .KEY_LEN    (KEY_LEN),
        .DATA_LEN   (DATA_LEN),
        .DEFAULT_KEY(DEF_KEY)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_idx    (wr_idx),
        .wr_key    (wr_key),
        .wr_data   (wr_data),
        .clr       (clr),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_hit  (resp_hit),
        .resp_key  (resp_key),
        .resp_idx  (resp_idx),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic timeout(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: wait bound expired (cycle %0d)", name, cyc);
    endtask

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    typedef struct {
        logic       hit;
        logic [3:0] key;
        logic [1:0] idx;
        int         lat;
        int         acc;
    } exp_t;

    exp_t exp_q[$];

    logic        m_valid [NR_KEY];
    logic [3:0]  m_key   [NR_KEY];
    logic [31:0] m_data  [NR_KEY];

    function automatic exp_t model_search(input logic [31:0] d);
        exp_t e;
        e.hit = 1'b0; e.key = DEF_KEY; e.idx = '0; e.lat = NR_KEY; e.acc = 0;
        for (int i = 0; i < NR_KEY; i++) begin
            if (m_valid[i] && m_data[i] == d) begin
                e.hit = 1'b1; e.key = m_key[i]; e.idx = IDX_W'(i); e.lat = i + 1;
                break;
            end
        end
        return e;
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < NR_KEY; i++) m_valid[i] = 1'b0;
    endfunction

    // ------------------------------------------------------------------
    // Monitor: owns resp_ready, pops expectations on each new response
    // ------------------------------------------------------------------
    int          stall_n = 0;
    bit          rand_bp = 1'b0;
    int          last_hs = -100;
    bit          in_resp = 1'b0;
    bit          stable_ok;
    logic [6:0]  held;
    exp_t        cur;

    always @(negedge clk) begin
        if (!rst_n) begin
            in_resp    = 1'b0;
            resp_ready = 1'b0;
        end else begin
            if (resp_valid && !in_resp) begin
                in_resp   = 1'b1;
                stable_ok = 1'b1;
                held      = {resp_hit, resp_key, resp_idx};
                check("resp_expected", exp_q.size() > 0, 1'b1);
                if (exp_q.size() > 0) begin
                    cur = exp_q.pop_front();
                    check("resp_hit", resp_hit, cur.hit);
                    check("resp_key", resp_key, cur.key);
                    check("resp_idx", resp_idx, cur.idx);
                    check("resp_latency", cyc - cur.acc, cur.lat);
                end
            end
            if (in_resp) begin
                if (!resp_valid || {resp_hit, resp_key, resp_idx} !== held) stable_ok = 1'b0;
                if (stall_n > 0) begin
                    resp_ready = 1'b0;
                    stall_n--;
                end else begin
                    resp_ready = rand_bp ? ($urandom_range(3) != 0) : 1'b1;
                end
                if (resp_ready) begin
                    check("resp_stable", stable_ok, 1'b1);
                    in_resp = 1'b0;
                    last_hs = cyc + 1;
                end
            end else begin
                resp_ready = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Driver tasks (all entered and left on a falling edge)
    // ------------------------------------------------------------------
    task automatic tbl_write(input int idx, input logic [3:0] k, input logic [31:0] d,
                             input bit with_clr);
        wr_en = 1'b1; wr_idx = IDX_W'(idx); wr_key = k; wr_data = d; clr = with_clr;
        @(negedge clk);
        wr_en = 1'b0; clr = 1'b0;
        if (with_clr) model_clear();
        m_valid[idx] = 1'b1; m_key[idx] = k; m_data[idx] = d;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        model_clear();
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy || exp_q.size() != 0) begin
            @(negedge clk);
            n++;
            if (n > 200) begin
                timeout("wait_idle");
                exp_q.delete();
                return;
            end
        end
    endtask

    // Issues one request, holding req_valid until accepted; acc = accept edge.
    task automatic send(input logic [31:0] d, input exp_t e, input bit chk_b2b, output int acc);
        int n = 0;
        acc = -1;
        req_data  = d;
        req_valid = 1'b1;
        while (!req_ready) begin
            @(negedge clk);
            n++;
            if (n > 200) begin
                timeout("req_accept");
                req_valid = 1'b0;
                return;
            end
        end
        acc   = cyc + 1;
        e.acc = acc;
        if (chk_b2b) check("accept_after_handshake", acc, last_hs + 1);
        exp_q.push_back(e);
        @(negedge clk);
        req_valid = 1'b0;
        req_data  = $urandom;
    endtask

    task automatic search(input logic [31:0] d);
        int acc;
        send(d, model_search(d), 1'b0, acc);
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    logic [31:0] pool [8];

    initial begin
        int          acc_a, acc_b;
        exp_t        e;
        logic [31:0] d;
        int          r;

        rst_n = 1'b0; wr_en = 1'b0; wr_idx = '0; wr_key = '0; wr_data = '0;
        clr = 1'b0; req_valid = 1'b0; req_data = '0;
        model_clear();
        for (int i = 0; i < NR_KEY; i++) begin m_key[i] = '0; m_data[i] = '0; end

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_req_ready", req_ready, 1'b1);
        check("rst_resp_valid", resp_valid, 1'b0);
        check("rst_resp_hit", resp_hit, 1'b0);
        check("rst_resp_key", resp_key, 4'h0);
        check("rst_resp_idx", resp_idx, 2'd0);
        check("rst_busy", busy, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // Hit on entry 2 (latency 3), then miss (latency 4, default key)
        tbl_write(1, 4'hA, 32'h100, 1'b0);
        tbl_write(2, 4'h5, 32'h200, 1'b0);
        search(32'h200);
        wait_idle();
        search(32'hDEAD);
        wait_idle();

        // Duplicate data: lowest index wins, latency 1
        tbl_write(0, 4'h1, 32'h42, 1'b0);
        tbl_write(3, 4'h7, 32'h42, 1'b0);
        search(32'h42);
        wait_idle();

        // Back-pressure: response held 5 cycles, second request waits for it
        stall_n = 5;
        send(32'h200, model_search(32'h200), 1'b0, acc_a);
        send(32'h100, model_search(32'h100), 1'b1, acc_b);
        // hit at idx 2 -> resp after acc+3, 5 stalled cycles, handshake at acc+9
        check("bp_accept_edge", acc_b - acc_a, 10);
        wait_idle();

        // clr + write entry 3 at the edge that decides ptr=1
        tbl_write(0, 4'h1, 32'h11, 1'b0);
        tbl_write(1, 4'h2, 32'h22, 1'b0);
        tbl_write(2, 4'h3, 32'h1234_5678, 1'b0);
        tbl_write(3, 4'h4, 32'h44, 1'b0);
        e.hit = 1'b1; e.key = 4'h9; e.idx = 2'd3; e.lat = 4; e.acc = 0;
        send(32'h1234_5678, e, 1'b0, acc_a);
        @(negedge clk);
        tbl_write(3, 4'h9, 32'h1234_5678, 1'b1);
        wait_idle();

        // Reset in the middle of a search: no response, table emptied
        tbl_write(3, 4'hC, 32'h77, 1'b0);
        search(32'h77);
        @(negedge clk);
        rst_n = 1'b0;
        exp_q.delete();
        model_clear();
        #1;
        check("midrst_req_ready", req_ready, 1'b1);
        check("midrst_busy", busy, 1'b0);
        check("midrst_resp_valid", resp_valid, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (NR_KEY + 3) @(negedge clk);
        search(32'h77);
        wait_idle();

        // Randomized traffic with table updates between searches
        pool[0] = 32'h0;         pool[1] = 32'hFFFF_FFFF; pool[2] = 32'h8000_0000;
        pool[3] = 32'h0000_0001; pool[4] = 32'hCAFE_F00D; pool[5] = 32'h1234_5678;
        pool[6] = 32'hCAFE_F00C; pool[7] = 32'h7FFF_FFFF;
        rand_bp = 1'b1;
        for (int it = 0; it < 60; it++) begin
            wait_idle();
            r = $urandom_range(9);
            if (r == 0) do_clr();
            else if (r < 7) tbl_write($urandom_range(NR_KEY - 1), 4'($urandom),
                                      pool[$urandom_range(5)], r == 1);
            d = pool[$urandom_range(7)];
            search(d);
        end
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        timeout("global_watchdog");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ysyx_22050612_key_search.md
Name: ysyx_22050612_key_search

Overview:
- Reverse of the key→data mux lookup: a programmable table of NR_KEY {key, data} pairs plus a sequential search engine.
- Given a data value, the engine scans entries one per cycle and returns the key of the first matching valid entry, or DEFAULT_KEY on miss.
- Used by NPC decode/CSR logic wherever a value must be mapped back to its selector code.
- Requests and responses use valid/ready handshakes.

Parameters:
- NR_KEY, 4, number of table entries (≥2).
- KEY_LEN, 4, key width.
- DATA_LEN, 32, data width.
- DEFAULT_KEY, 0, key returned on miss (KEY_LEN bits).
- IDX_W, derived = max(1, clog2(NR_KEY)), entry index width.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- wr_en  in  1  write entry wr_idx at this edge.
- wr_idx  in  IDX_W  entry to write; values ≥NR_KEY ignored.
- wr_key  in  KEY_LEN  key to store.
- wr_data  in  DATA_LEN  data to store.
- clr  in  1  invalidate all entries.
- req_valid  in  1  search request valid.
- req_ready  out  1  engine can accept request.
- req_data  in  DATA_LEN  value to search for.
- resp_valid  out  1  result valid.
- resp_ready  in  1  consumer accepts result.
- resp_hit  out  1  1 = match found.
- resp_key  out  KEY_LEN  matched key, or DEFAULT_KEY on miss.
- resp_idx  out  IDX_W  matched entry index, 0 on miss.
- busy  out  1  state != IDLE.

Behaviour:
- Table
  - Per entry: valid bit, key, data.
  - Write at edge: wr_en sets valid=1, key=wr_key, data=wr_data.
  - clr at edge: all valid bits go to 0.
  - clr and wr_en at the same edge: clear first, then write, so only wr_idx stays valid.
  - Writes are allowed in every FSM state.
- Reset (rst_n low, async)
  - state=IDLE; all valid, key and data storage = 0.
  - resp_valid=0, resp_hit=0, resp_key=0, resp_idx=0, busy=0.
  - req_ready=1, since it is decoded from IDLE.
  - Reset mid-search or mid-response aborts the search and drops the result; no response is issued.
- FSM states: IDLE, SEARCH, RESP.
  - IDLE: req_ready=1. On req_valid&&req_ready at an edge: latch req_data into q, set ptr=0, go to SEARCH.
  - SEARCH: req_ready=0. Each cycle compares entry[ptr] against q, using valid && data==q.
    - Hit: at the edge, register resp_hit=1, resp_key=key[ptr], resp_idx=ptr; go to RESP.
    - No hit and ptr==NR_KEY-1: register resp_hit=0, resp_key=DEFAULT_KEY, resp_idx=0; go to RESP.
    - Otherwise: ptr+1.
  - RESP: resp_valid=1. resp_* held stable until resp_ready. On resp_valid&&resp_ready at an edge: resp_valid drops to 0, go to IDLE.
- No back-to-back acceptance: a new request is accepted no earlier than the edge after the response handshake, so there is at most one request in flight.
- Latency
  - Accept at edge E0.
  - Hit on entry k: resp_valid high after edge E(k+1).
  - Miss: resp_valid high after edge E(NR_KEY).
- Priority: the lowest index wins when several valid entries hold equal data.
- Table changes during a search
  - The compare uses the table contents present in that cycle.
  - A write to an entry not yet scanned is visible to the search.
  - A write to an entry already scanned does not affect the result.
  - clr during SEARCH causes a miss unless a later scanned entry is rewritten.
- Arithmetic: ptr wraps only through the FSM, never by overflow. Compares are exact, full DATA_LEN equality.

Test Plan:
- Reset then check outputs: req_ready=1, resp_valid=0, resp_key=0, busy=0.
- Hit timing: write {1:0xA,0x100},{2:0x5,0x200}, then search 0x200. Required: resp_valid 3 edges after accept, hit=1, key=0x5, idx=2.
- Miss: search 0xDEAD on the table above with DEFAULT_KEY=0xF. Required: resp_valid after 4 edges, hit=0, key=0xF, idx=0.
- Duplicate data: entries 0 and 3 both hold 0x42 with keys 0x1 and 0x7. Required: key=0x1, idx=0, 1-edge latency.
- Back-pressure: hold resp_ready=0 for 5 cycles. Required: resp_* stable, req_ready=0 while req_valid is held high, then next request accepted on the edge after the handshake.
- Mid-search events:
  - clr+wr_en(idx3, key 0x9, data Q) at the same edge during ptr=1. Required: hit, key=0x9, idx=3.
  - Separately, assert rst_n=0 during SEARCH. Required: immediate IDLE, no response, table invalid.
